_updown_counter: RTL
====================

// Module: _updown_counter
// PURPOSE
//  Loadable up/down binary counter with terminal-count and wrap flags.
//  Consumes the gate library (_inv, _and2, _or2, _xor2 and wider variants) for its
//  next-state logic. Holds state in async-reset D flip-flops, one per bit plus flags.
//  Feeds timer/sequencer stages that need a count value and one-cycle wrap events.
// PARAMETERS
//  WIDTH      4   counter width in bits (legal: 2..32)
//  RESET_VAL  0   value loaded into q on reset (must fit in WIDTH bits)
// PORTS
//  clk      in   1      rising-edge clock; the only clock
//  reset_n  in   1      asynchronous, active-low reset
//  load     in   1      load d_in into q next edge (highest priority)
//  inc      in   1      count up by 1 next edge
//  dec      in   1      count down by 1 next edge
//  d_in     in   WIDTH  parallel load value
//  q        out  WIDTH  registered count
//  tc_up    out  1      combinational: q == 2^WIDTH-1
//  tc_dn    out  1      combinational: q == 0
//  carry    out  1      registered: 1 for the cycle after an up-wrap (max -> 0)
//  borrow   out  1      registered: 1 for the cycle after a down-wrap (0 -> max)
// BEHAVIOUR
//  - Reset (reset_n=0, any time, no clock needed): q=RESET_VAL, carry=0, borrow=0.
//    tc_up/tc_dn follow q. Reset mid-count discards the pending op.
//  - Latency: ops take effect on the first rising clk edge after they are sampled high.
//    carry/borrow assert on that same edge and clear on the next edge unless re-caused.
//  - Per-edge op select, in priority order:
//    load=1            -> q=d_in, carry=0, borrow=0 (inc/dec ignored)
//    inc=1, dec=0      -> q=q+1 mod 2^WIDTH; carry=1 iff old q==max
//    inc=0, dec=1      -> q=q-1 mod 2^WIDTH; borrow=1 iff old q==0
//    inc=dec=1 or none -> q holds, carry=0, borrow=0
//  - Arithmetic is unsigned WIDTH-bit. No overflow beyond the wrap flags.
//  - Incrementer: ripple half-adder chain (_xor2/_and2). Decrementer: complement chain.
//    A WIDTH-bit 2:1/3:1 select built from gate cells chooses next-state.
//  - carry and borrow are never both 1.
//  - Loading a value equal to max or 0 sets tc_up/tc_dn immediately after the edge.
//    The load does not assert carry/borrow.
// CONFIGURATION
//  SATURATE_EN defined:
//    inc at max holds q=max; dec at 0 holds q=0.
//    carry/borrow still pulse 1 cycle on each such blocked attempt (overflow indicator).
//  SATURATE_EN undefined: wrap-around as above (default build).
//  No other behaviour differs between builds.
// TESTING (WIDTH=4, RESET_VAL=0)
//  1. reset_n=0 mid-count at q=7, no clk edge -> q=0, carry=0, borrow=0, tc_dn=1 at once.
//  2. load=1, d_in=4'hE, then inc x2 -> q=E, F (tc_up=1), 0.
//     carry=1 only the cycle q=0 is shown.
//  3. q=0, dec=1 one cycle -> q=F, borrow=1 for one cycle, then borrow=0 with dec low.
//  4. q=5, inc=dec=1 -> q stays 5.
//     q=5, load=1, inc=1, d_in=9 -> q=9, carry=0.
//  5. SATURATE_EN: q=F, inc x3 -> q stays F, carry=1 each of 3 cycles.
//     q=0, dec -> q=0, borrow=1.
//  6. Random load/inc/dec for 1000 cycles vs behavioural model.
//     Includes async resets at random offsets. q/carry/borrow match every cycle.

Source files
------------

// File: rtl/_updown_counter.sv
// _updown_counter: loadable up/down counter with terminal-count and one-cycle wrap flags.
// Build with SATURATE_EN defined to clamp at max/0 instead of wrapping.
module _updown_counter #(
  parameter int WIDTH = 4,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q,
  output logic             tc_up,
  output logic             tc_dn,
  output logic             carry,
  output logic             borrow
);
  logic [WIDTH:0]   c;
  logic [WIDTH:0]   b;
  logic [WIDTH-1:0] inc_s;
  logic [WIDTH-1:0] dec_s;
  logic [WIDTH-1:0] nxt;
  logic             up;
  logic             dn;
  logic             up_go;
  logic             dn_go;
  assign c[0] = 1'b1;
  assign b[0] = 1'b1;
  // Ripple chains: the final carry/borrow terms double as the terminal-count detectors.
  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    assign inc_s[i] = q[i] ^ c[i];
    assign c[i+1]   = q[i] & c[i];
    assign dec_s[i] = q[i] ^ b[i];
    assign b[i+1]   = ~q[i] & b[i];
  end
  assign tc_up = c[WIDTH];
  assign tc_dn = b[WIDTH];
  assign up = ~load & inc & ~dec;
  assign dn = ~load & dec & ~inc;
`ifdef SATURATE_EN
  assign up_go = up & ~tc_up;
  assign dn_go = dn & ~tc_dn;
`else
  assign up_go = up;
  assign dn_go = dn;
`endif
  assign nxt = load ? d_in : up_go ? inc_s : dn_go ? dec_s : q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q      <= WIDTH'(RESET_VAL);
      carry  <= 1'b0;
      borrow <= 1'b0;
    end else begin
      q      <= nxt;
      carry  <= up & tc_up;
      borrow <= dn & tc_dn;
    end
  end
endmodule
